uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes enter a small FIFO over a valid/ready handshake. An IDLE/START/DATA/STOP
// state machine pops them one at a time and shifts them out LSB first on a
// registered, idle-high serial line. After each stop bit it pulses tx_done for
// one cycle.
module uart_tx_fifo #(
  parameter int DIVISOR    = 347,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [4:0] fifo_count
);

  localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [15:0] LAST_TICK = 16'(DIVISOR - 1);
  localparam logic [15:0] DONE_TICK = 16'(DIVISOR - 2);
  localparam logic [4:0]  DEPTH_CNT = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       count;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             push;
  logic             pop;
  logic             bit_end;

  // A full FIFO refuses pushes. A pop in that same cycle cannot help until the
  // registered count drops on the next edge.
  assign tx_ready   = (count < DEPTH_CNT);
  assign push       = tx_valid && tx_ready;
  assign pop        = (state == IDLE) && (count != 5'd0);
  assign bit_end    = (baud_cnt == LAST_TICK);
  assign fifo_count = count;

  // Byte storage. It has no reset because the pointers alone decide which entries are valid.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers wrap naturally at the power-of-two depth. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: ;
      endcase
    end
  end

  // Frame sequencer with registered line/busy/done outputs. tx_done is set one
  // tick early so that it is high exactly during the last stop-bit cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            tx        <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_cnt == DONE_TICK) begin
            tx_done <= 1'b1;
          end
          if (bit_end) begin
            baud_cnt <= 16'd0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// Instance dut4 runs at a divisor of 4 for the fast tests. Instance dut347 uses
// the default 115200-baud divisor. A mid-bit UART receiver decodes both lines.
module tb_uart_tx_fifo;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       framing_ok;
  } rx_t;

  logic       clk;
  logic       rst;
  logic [7:0] data4;
  logic       valid4;
  logic       ready4;
  logic       tx4;
  logic       busy4;
  logic       done4;
  logic [4:0] count4;
  logic [7:0] data347;
  logic       valid347;
  logic       ready347;
  logic       tx347;
  logic       busy347;
  logic       done347;
  logic [4:0] count347;

  int   tests = 0;
  int   failures = 0;
  int   cyc = 0;

  rx_t        rxq0[$];
  rx_t        rxq1[$];
  logic       rx_busy   [2] = '{1'b0, 1'b0};
  int         rx_start  [2] = '{0, 0};
  logic [7:0] rx_shift  [2] = '{8'd0, 8'd0};
  logic       rx_startok[2] = '{1'b0, 1'b0};
  int         done_cnt  [2] = '{0, 0};
  int         last_done [2] = '{0, 0};
  int         low_cnt   [2] = '{0, 0};

  uart_tx_fifo #(.DIVISOR(4), .FIFO_DEPTH(8)) dut4 (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .tx_data   (data4),
    .tx_valid  (valid4),
    .tx_ready  (ready4),
    .tx        (tx4),
    .busy      (busy4),
    .tx_done   (done4),
    .fifo_count(count4)
  );

  uart_tx_fifo dut347 (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .tx_data   (data347),
    .tx_valid  (valid347),
    .tx_ready  (ready347),
    .tx        (tx347),
    .busy      (busy347),
    .tx_done   (done347),
    .fifo_count(count347)
  );

  // Free-running clock and edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-bit UART receiver and strobe monitor for both lines, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    logic ln;
    logic dn;
    int   d;
    int   off;
    int   b;
    rx_t  e;
    for (int c = 0; c < 2; c++) begin
      ln = (c == 0) ? tx4 : tx347;
      dn = (c == 0) ? done4 : done347;
      d  = (c == 0) ? 4 : 347;
      if (rst) begin
        rx_busy[c] = 1'b0;
      end else begin
        if (dn) begin
          done_cnt[c]  = done_cnt[c] + 1;
          last_done[c] = cyc;
        end
        if (!ln) low_cnt[c] = low_cnt[c] + 1;
        if (!rx_busy[c]) begin
          if (!ln) begin
            rx_busy[c]  = 1'b1;
            rx_start[c] = cyc;
          end
        end else begin
          off = cyc - rx_start[c];
          if (off % d == d / 2) begin
            b = off / d;
            if (b == 0) rx_startok[c] = !ln;
            else if (b <= 8) rx_shift[c][b-1] = ln;
            else begin
              e.data       = rx_shift[c];
              e.start      = rx_start[c];
              e.framing_ok = rx_startok[c] && ln;
              if (c == 0) rxq0.push_back(e);
              else rxq1.push_back(e);
              rx_busy[c] = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    valid4 = v;
    data4  = d;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin : stimulus
    int         n;
    int         base;
    int         d0;
    int         l0;
    logic [40:0] obs_tx;
    logic [40:0] obs_done;
    logic [40:0] exp_tx;
    logic [40:0] exp_done;
    logic [7:0]  b55;
    logic [7:0]  exp_seq [10];

    rst      = 1'b1;
    valid4   = 1'b0;
    data4    = 8'd0;
    valid347 = 1'b0;
    data347  = 8'd0;
    repeat (3) tick();

    // Reset state
    checkOutput("reset tx", tx4, 1);
    checkOutput("reset busy", busy4, 0);
    checkOutput("reset ready", ready4, 1);
    checkOutput("reset count", count4, 0);
    checkOutput("reset done", done4, 0);
    checkOutput("reset tx347", tx347, 1);
    rst = 1'b0;
    repeat (100) tick();
    checkOutput("idle done pulses", done_cnt[0], 0);
    checkOutput("idle tx low cycles", low_cnt[0], 0);
    checkOutput("idle tx", tx4, 1);
    checkOutput("idle busy", busy4, 0);
    checkOutput("idle ready", ready4, 1);
    checkOutput("idle count", count4, 0);

    // Single byte 0x55 with an exact per-cycle waveform
    base = rxq0.size();
    applyStimulus(1'b1, 8'h55);
    valid4 = 1'b0;
    n = cyc;
    checkOutput("single push count", count4, 1);
    checkOutput("single push tx", tx4, 1);
    for (int k = 1; k <= 41; k++) begin
      tick();
      obs_tx[k-1]   = tx4;
      obs_done[k-1] = done4;
      if (k == 1) checkOutput("single busy after pop", busy4, 1);
    end
    b55 = 8'h55;
    for (int k = 1; k <= 41; k++) begin
      if (k <= 4) exp_tx[k-1] = 1'b0;
      else if (k <= 36) exp_tx[k-1] = b55[(k-5)/4];
      else exp_tx[k-1] = 1'b1;
      exp_done[k-1] = (k == 40);
    end
    checkOutput("single tx waveform", obs_tx, exp_tx);
    checkOutput("single done waveform", obs_done, exp_done);
    checkOutput("single busy end", busy4, 0);
    checkOutput("single rx count", rxq0.size() - base, 1);
    if (rxq0.size() > base) begin
      checkOutput("single rx data", rxq0[base].data, 8'h55);
      checkOutput("single rx start", rxq0[base].start, n + 1);
      checkOutput("single rx framing", rxq0[base].framing_ok, 1);
    end
    checkOutput("single done cycle", last_done[0], n + 40);

    // Fill to full, then an overflow push that must be dropped
    repeat (5) tick();
    base = rxq0.size();
    d0   = done_cnt[0];
    n    = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("fill ready %0d", i), ready4, 1);
      applyStimulus(1'b1, 8'(i + 1));
    end
    checkOutput("full count", count4, 8);
    checkOutput("full ready", ready4, 0);
    applyStimulus(1'b1, 8'h0A);
    valid4 = 1'b0;
    checkOutput("overflow count", count4, 8);
    repeat (400) tick();
    checkOutput("fill rx count", rxq0.size() - base, 9);
    checkOutput("fill done pulses", done_cnt[0] - d0, 9);
    checkOutput("fill drained count", count4, 0);
    if (rxq0.size() >= base + 9) begin
      for (int i = 0; i < 9; i++) begin
        checkOutput($sformatf("fill rx data %0d", i), rxq0[base+i].data, 8'(i + 1));
        checkOutput($sformatf("fill rx start %0d", i), rxq0[base+i].start, n + 1 + 41 * i);
      end
    end

    // Push refused at full while IDLE pops, then accepted the next cycle
    base = rxq0.size();
    applyStimulus(1'b1, 8'h11);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h12 + 8'(i));
    checkOutput("pp full count", count4, 8);
    checkOutput("pp full ready", ready4, 0);
    repeat (5) applyStimulus(1'b1, 8'hEE);
    valid4 = 1'b0;
    checkOutput("pp held valid count", count4, 8);
    for (int t = 0; t < 100 && busy4 !== 1'b0; t++) tick();
    checkOutput("pp idle busy", busy4, 0);
    checkOutput("pp idle count", count4, 8);
    checkOutput("pp idle ready", ready4, 0);
    applyStimulus(1'b1, 8'hA5);
    checkOutput("pp after pop count", count4, 7);
    checkOutput("pp after pop ready", ready4, 1);
    checkOutput("pp after pop busy", busy4, 1);
    tick();
    valid4 = 1'b0;
    checkOutput("pp accepted count", count4, 8);
    repeat (450) tick();
    exp_seq[0] = 8'h11;
    for (int i = 1; i < 9; i++) exp_seq[i] = 8'h11 + 8'(i);
    exp_seq[9] = 8'hA5;
    checkOutput("pp rx count", rxq0.size() - base, 10);
    if (rxq0.size() >= base + 10) begin
      for (int i = 0; i < 10; i++) begin
        checkOutput($sformatf("pp rx data %0d", i), rxq0[base+i].data, exp_seq[i]);
        checkOutput($sformatf("pp rx framing %0d", i), rxq0[base+i].framing_ok, 1);
      end
    end

    // Reset in DATA bit 3 of 0xF0 with three bytes queued
    repeat (3) tick();
    applyStimulus(1'b1, 8'hF0);
    n = cyc;
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h03);
    valid4 = 1'b0;
    checkOutput("mid queued count", count4, 3);
    for (int t = 0; t < 50 && cyc < n + 18; t++) tick();
    checkOutput("mid bit3 tx", tx4, 0);
    checkOutput("mid bit3 busy", busy4, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid async tx", tx4, 1);
    checkOutput("mid async count", count4, 0);
    checkOutput("mid async busy", busy4, 0);
    checkOutput("mid async done", done4, 0);
    checkOutput("mid async ready", ready4, 1);
    repeat (3) tick();
    base = rxq0.size();
    d0   = done_cnt[0];
    l0   = low_cnt[0];
    rst  = 1'b0;
    repeat (200) tick();
    checkOutput("post reset done pulses", done_cnt[0] - d0, 0);
    checkOutput("post reset tx low cycles", low_cnt[0] - l0, 0);
    checkOutput("post reset rx frames", rxq0.size() - base, 0);
    checkOutput("post reset count", count4, 0);
    checkOutput("post reset busy", busy4, 0);

    // Default divisor: 0x0D at 115200 baud, 3470-cycle frame
    base     = rxq1.size();
    d0       = done_cnt[1];
    data347  = 8'h0D;
    valid347 = 1'b1;
    tick();
    valid347 = 1'b0;
    n = cyc;
    for (int t = 0; t < 4000 && done_cnt[1] == d0; t++) tick();
    checkOutput("baud done pulses", done_cnt[1] - d0, 1);
    checkOutput("baud done cycle", last_done[1], n + 3470);
    checkOutput("baud rx count", rxq1.size() - base, 1);
    if (rxq1.size() > base) begin
      checkOutput("baud rx data", rxq1[base].data, 8'h0D);
      checkOutput("baud rx start", rxq1[base].start, n + 1);
      checkOutput("baud frame length", last_done[1] - rxq1[base].start + 1, 3470);
      checkOutput("baud rx framing", rxq1[base].framing_ok, 1);
    end
    repeat (5) tick();
    checkOutput("baud idle tx", tx347, 1);
    checkOutput("baud idle busy", busy347, 0);
    checkOutput("baud idle ready", ready347, 1);
    checkOutput("baud idle count", count347, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
